// File: rtl/exec_scoreboard.sv
// Issue-stage scoreboard: per-register busy counters plus a writeback slot
// vector that enforces RAW/WAW ordering and a single writeback port.
module exec_scoreboard #(
  parameter int NUM_REGS = 128,
  parameter int MAX_LAT  = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [6:0]  src_a,
  input  logic [6:0]  src_b,
  input  logic [6:0]  src_c,
  input  logic        src_a_en,
  input  logic        src_b_en,
  input  logic        src_c_en,
  input  logic [6:0]  dst_rt,
  input  logic        dst_we,
  input  logic [2:0]  lat,
  output logic        wb_valid,
  output logic [6:0]  wb_rt,
  output logic [15:0] stall_count
);

  logic [2:0]            cnt_r [NUM_REGS];
  logic [MAX_LAT:1]      slot_v_r;
  logic [MAX_LAT:1]      slot_v_shift_s;
  logic [MAX_LAT:1]      slot_v_next_s;
  logic [MAX_LAT:1][6:0] tag_r;
  logic [MAX_LAT:1][6:0] tag_shift_s;
  logic [MAX_LAT:1][6:0] tag_next_s;
  logic [2:0]            eff_lat_s;
  logic                  raw_s;
  logic                  waw_s;
  logic                  slot_conflict_s;
  logic                  issue_s;

  // Latency class clamped into 1..MAX_LAT (0 behaves as 1)
  always_comb begin
    if (lat == 3'd0) begin
      eff_lat_s = 3'd1;
    end else if (lat > 3'(MAX_LAT)) begin
      eff_lat_s = 3'(MAX_LAT);
    end else begin
      eff_lat_s = lat;
    end
  end

  // Slot contents as they will look after this cycle's shift
  assign slot_v_shift_s = {1'b0, slot_v_r[MAX_LAT:2]};
  assign tag_shift_s    = {7'd0, tag_r[MAX_LAT:2]};

  // Hazard detection; a source equal to dst_rt only sees the current busy state
  always_comb begin
    raw_s = (src_a_en && (cnt_r[src_a] != 3'd0)) ||
            (src_b_en && (cnt_r[src_b] != 3'd0)) ||
            (src_c_en && (cnt_r[src_c] != 3'd0));
    waw_s = dst_we && (cnt_r[dst_rt] != 3'd0);
    slot_conflict_s = 1'b0;
    for (int i = 1; i <= MAX_LAT; i++) begin
      if (eff_lat_s == 3'(i)) begin
        slot_conflict_s = slot_v_shift_s[i];
      end else begin
        slot_conflict_s = slot_conflict_s;
      end
    end
    issue_ready = !(raw_s || waw_s || (dst_we && slot_conflict_s));
    issue_s     = issue_valid && issue_ready && dst_we;
  end

  // Next slot vector: shift toward slot 1 and insert the newly issued writeback
  always_comb begin
    slot_v_next_s = slot_v_shift_s;
    tag_next_s    = tag_shift_s;
    for (int i = 1; i <= MAX_LAT; i++) begin
      if (issue_s && (eff_lat_s == 3'(i))) begin
        slot_v_next_s[i] = 1'b1;
        tag_next_s[i]    = dst_rt;
      end else begin
        slot_v_next_s[i] = slot_v_shift_s[i];
        tag_next_s[i]    = tag_shift_s[i];
      end
    end
  end

  // Writeback slot registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_v_r <= '0;
      tag_r    <= '0;
    end else begin
      slot_v_r <= slot_v_next_s;
      tag_r    <= tag_next_s;
    end
  end

  // Busy counters: load on issue wins over the per-cycle decrement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_r[r] <= 3'd0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (issue_s && (dst_rt == 7'(r))) begin
          cnt_r[r] <= eff_lat_s;
        end else if (cnt_r[r] != 3'd0) begin
          cnt_r[r] <= cnt_r[r] - 3'd1;
        end else begin
          cnt_r[r] <= cnt_r[r];
        end
      end
    end
  end

  // Saturating stall counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= 16'd0;
    end else if (issue_valid && !issue_ready && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end else begin
      stall_count <= stall_count;
    end
  end

  assign wb_valid = slot_v_r[1];
  assign wb_rt    = tag_r[1];

endmodule

// File: tb/tb_exec_scoreboard.sv
// Self-checking bench for exec_scoreboard: directed scenarios plus random
// traffic compared against a timeline model of pending writebacks.
module tb_exec_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [6:0]  src_a, src_b, src_c;
  logic        src_a_en, src_b_en, src_c_en;
  logic [6:0]  dst_rt;
  logic        dst_we;
  logic [2:0]  lat;
  logic        wb_valid;
  logic [6:0]  wb_rt;
  logic [15:0] stall_count;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: absolute cycle of each register's last pending writeback, and
  // which register (if any) writes back in a given absolute cycle.
  int cyc;
  int last_wb [128];
  int wb_at [int];
  int model_stall;

  logic       obs_ready;
  logic       obs_wbv;
  logic [6:0] obs_wbrt;

  exec_scoreboard dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .src_a(src_a), .src_b(src_b), .src_c(src_c),
    .src_a_en(src_a_en), .src_b_en(src_b_en), .src_c_en(src_c_en),
    .dst_rt(dst_rt), .dst_we(dst_we), .lat(lat),
    .wb_valid(wb_valid), .wb_rt(wb_rt), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_lat(input logic [2:0] l);
    return (l == 3'd0) ? 1 : int'(l);
  endfunction

  function automatic bit busy(input logic [6:0] r);
    return last_wb[r] >= cyc;
  endfunction

  function automatic bit model_ready();
    if (src_a_en && busy(src_a)) return 1'b0;
    if (src_b_en && busy(src_b)) return 1'b0;
    if (src_c_en && busy(src_c)) return 1'b0;
    if (dst_we && busy(dst_rt)) return 1'b0;
    if (dst_we && wb_at.exists(cyc + eff_lat(lat))) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 128; r++) last_wb[r] = -100;
    wb_at.delete();
    model_stall = 0;
    cyc = 0;
  endtask

  task automatic set_in(input logic v, input logic [6:0] d, input logic we, input logic [2:0] l,
                        input logic [6:0] a, input logic aen);
    issue_valid = v; dst_rt = d; dst_we = we; lat = l;
    src_a = a; src_a_en = aen;
    src_b = 7'd0; src_b_en = 1'b0; src_c = 7'd0; src_c_en = 1'b0;
  endtask

  // One clock cycle: compare at negedge, then advance the model at posedge
  task automatic step();
    bit r;
    @(negedge clk);
    r = model_ready();
    obs_ready = issue_ready; obs_wbv = wb_valid; obs_wbrt = wb_rt;
    chk("issue_ready", {31'd0, issue_ready}, {31'd0, r});
    chk("wb_valid", {31'd0, wb_valid}, {31'd0, wb_at.exists(cyc)});
    if (wb_at.exists(cyc)) chk("wb_rt", {25'd0, wb_rt}, wb_at[cyc]);
    chk("stall_count", {16'd0, stall_count}, model_stall);
    @(posedge clk);
    if (issue_valid && !r && model_stall < 65535) model_stall++;
    if (issue_valid && r && dst_we) begin
      last_wb[dst_rt] = cyc + eff_lat(lat);
      wb_at[cyc + eff_lat(lat)] = int'(dst_rt);
    end
    wb_at.delete(cyc);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("reset_wb_rt", {25'd0, wb_rt}, 32'd0);
    chk("reset_stall", {16'd0, stall_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    reset = 1'b0;
    set_in(1'b0, 7'd0, 1'b0, 3'd0, 7'd0, 1'b0);
    @(posedge clk);
    #1;
    do_reset();

    // Basic latency and RAW stall: r5 lat 3
    set_in(1'b1, 7'd5, 1'b1, 3'd3, 7'd0, 1'b0); step();
    chk("s1_issue", {31'd0, obs_ready}, 32'd1);
    set_in(1'b1, 7'd0, 1'b0, 3'd0, 7'd5, 1'b1);
    step(); chk("s1_stall1", {31'd0, obs_ready}, 32'd0);
    step(); chk("s1_stall2", {31'd0, obs_ready}, 32'd0);
    step(); chk("s1_stall3", {31'd0, obs_ready}, 32'd0);
    chk("s1_wbv", {31'd0, obs_wbv}, 32'd1);
    chk("s1_wbrt", {25'd0, obs_wbrt}, 32'd5);
    step(); chk("s1_go", {31'd0, obs_ready}, 32'd1);
    set_in(1'b0, 7'd0, 1'b0, 3'd0, 7'd0, 1'b0); step();

    // Writeback-port conflict: r7 lat 4 then r8 lat 3
    do_reset();
    set_in(1'b1, 7'd7, 1'b1, 3'd4, 7'd0, 1'b0); step();
    set_in(1'b1, 7'd8, 1'b1, 3'd3, 7'd0, 1'b0);
    step(); chk("s2_conflict", {31'd0, obs_ready}, 32'd0);
    step(); chk("s2_go", {31'd0, obs_ready}, 32'd1);
    chk("s2_stall", {16'd0, stall_count}, 32'd1);
    set_in(1'b0, 7'd0, 1'b0, 3'd0, 7'd0, 1'b0);
    step();
    step(); chk("s2_wb7", {24'd0, obs_wbv, obs_wbrt}, {24'd0, 1'b1, 7'd7});
    step(); chk("s2_wb8", {24'd0, obs_wbv, obs_wbrt}, {24'd0, 1'b1, 7'd8});

    // WAW on r10
    do_reset();
    set_in(1'b1, 7'd10, 1'b1, 3'd2, 7'd0, 1'b0); step();
    set_in(1'b1, 7'd10, 1'b1, 3'd1, 7'd0, 1'b0);
    step(); chk("s3_waw1", {31'd0, obs_ready}, 32'd0);
    step(); chk("s3_waw2", {31'd0, obs_ready}, 32'd0);
    chk("s3_wb_first", {24'd0, obs_wbv, obs_wbrt}, {24'd0, 1'b1, 7'd10});
    step(); chk("s3_go", {31'd0, obs_ready}, 32'd1);
    chk("s3_gap", {31'd0, obs_wbv}, 32'd0);
    set_in(1'b0, 7'd0, 1'b0, 3'd0, 7'd0, 1'b0);
    step(); chk("s3_wb_second", {24'd0, obs_wbv, obs_wbrt}, {24'd0, 1'b1, 7'd10});

    // lat = 0 behaves as lat = 1
    do_reset();
    set_in(1'b1, 7'd3, 1'b1, 3'd0, 7'd0, 1'b0); step();
    set_in(1'b0, 7'd0, 1'b0, 3'd0, 7'd0, 1'b0);
    step(); chk("s4_wb", {24'd0, obs_wbv, obs_wbrt}, {24'd0, 1'b1, 7'd3});

    // Reset with three writebacks in flight plus some stalls
    do_reset();
    set_in(1'b1, 7'd1, 1'b1, 3'd7, 7'd0, 1'b0); step();
    set_in(1'b1, 7'd2, 1'b1, 3'd5, 7'd0, 1'b0); step();
    set_in(1'b1, 7'd4, 1'b1, 3'd3, 7'd0, 1'b0); step();
    set_in(1'b1, 7'd0, 1'b0, 3'd0, 7'd1, 1'b1); step();
    do_reset();
    step(); chk("s5_ready_after", {31'd0, obs_ready}, 32'd1);
    set_in(1'b0, 7'd0, 1'b0, 3'd0, 7'd0, 1'b0);
    for (int i = 0; i < 10; i++) step();

    // Random traffic over a small register window to provoke hazards
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      issue_valid = ($urandom_range(0, 3) != 0);
      src_a = 7'($urandom_range(0, 15)); src_a_en = 1'($urandom_range(0, 1));
      src_b = 7'($urandom_range(0, 15)); src_b_en = 1'($urandom_range(0, 1));
      src_c = 7'($urandom_range(0, 15)); src_c_en = 1'($urandom_range(0, 1));
      dst_rt = 7'($urandom_range(0, 15)); dst_we = 1'($urandom_range(0, 1));
      lat = 3'($urandom_range(0, 7));
      step();
    end

    // Saturation: keep r1 busy and keep offering a reader of r1
    do_reset();
    for (int i = 0; i < 75000; i++) begin
      if (busy(7'd1)) set_in(1'b1, 7'd0, 1'b0, 3'd0, 7'd1, 1'b1);
      else            set_in(1'b1, 7'd1, 1'b1, 3'd7, 7'd0, 1'b0);
      step();
    end
    @(negedge clk);
    chk("stall_saturated", {16'd0, stall_count}, 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
